// File: rtl/ew_fifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the asynchronous FIFO.
// Publishes a registered Gray write pointer and derives full/almost_full/count/overflow.
module ew_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 2,
   parameter int ERR_MODE   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_n,
   input  logic                  push,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_s,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  almost_full,
   output logic                  full,
   output logic                  overflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [PW-1:0] AF_THR = DEPTH - PW'(AF_LEVEL);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] gray_q, gray_d;
   logic [PW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] rptr_bin;
   logic          reject;

   // Accept decision uses the registered full, so a push can never race the flag.
   assign wr_en    = push & ~full_q & init_n;
   assign reject   = push & full_q & init_n;
   assign rptr_bin = gray2bin(rd_ptr_gray_s);

   always_comb begin
      wptr_d  = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
      gray_d  = bin2gray(wptr_d);
      count_d = wptr_d - rptr_bin;
      full_d  = (count_d == DEPTH);
      af_d    = (count_d >= AF_THR);
      ovf_d   = (ERR_MODE == 1) ? reject : (ovf_q | reject);
      if (!init_n) begin
         wptr_d  = '0;
         gray_d  = '0;
         count_d = '0;
         full_d  = 1'b0;
         af_d    = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         gray_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         gray_q  <= gray_d;
         count_q <= count_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wr_addr     = wptr_q[ADDR_WIDTH-1:0];
   assign wr_ptr_gray = gray_q;
   assign wr_count    = count_q;
   assign almost_full = af_q;
   assign full        = full_q;
   assign overflow    = ovf_q;

endmodule
